// File: rtl/vga_timing_pkg.sv
// VGA timing generator shared constants and helpers.
// Default timing is 640x480 at 800x525 total.
package vga_timing_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam int DEF_COL_W    = 10;
  localparam int DEF_ROW_W    = 9;
  localparam int DEF_PREFETCH = 32;

  function automatic int h_total(
    input int act, input int fp,
    input int sync, input int bp
  );
    return act + fp + sync + bp;
  endfunction

  function automatic int v_total(
    input int act, input int fp,
    input int sync, input int bp
  );
    return act + fp + sync + bp;
  endfunction

  // Bits needed to hold values 0..v-1.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle between generator and
// colour generator / line fetcher.
interface vga_timing_gen_if
  import vga_timing_pkg::*;
#(
  parameter int COL_W = DEF_COL_W,
  parameter int ROW_W = DEF_ROW_W
) ();

  logic             pixEn;
  logic             hSync;
  logic             vSync;
  logic             displayActive;
  logic [COL_W-1:0] column;
  logic [ROW_W-1:0] row;
  logic             frameStart;
  logic             lineFetch;
  logic [ROW_W-1:0] fetchRow;

  modport master (
    input  pixEn,
    output hSync, vSync, displayActive,
    output column, row,
    output frameStart, lineFetch, fetchRow
  );

  modport slave (
    output pixEn,
    input  hSync, vSync, displayActive,
    input  column, row,
    input  frameStart, lineFetch, fetchRow
  );

endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter with
// active and sync window decode of the next position.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int ACTIVE = DEF_H_ACTIVE,
  parameter int FP     = DEF_H_FP,
  parameter int SYNC   = DEF_H_SYNC,
  parameter int BP     = DEF_H_BP,
  parameter int W      = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en_i,
  output logic         wrap_o,
  output logic [W-1:0] next_o,
  output logic         active_o,
  output logic         sync_o
);

  localparam int TOTAL = ACTIVE + FP + SYNC + BP;
  localparam logic [W-1:0] LAST = W'(TOTAL - 1);
  localparam logic [W-1:0] ACT  = W'(ACTIVE);
  localparam logic [W-1:0] S_LO = W'(ACTIVE + FP);
  localparam logic [W-1:0] S_HI = W'(ACTIVE + FP + SYNC);

  logic [W-1:0] cnt_q, cnt_d;

  // Step on enable, wrap at the last position.
  always_comb begin
    wrap_o = en_i && (cnt_q == LAST);
    cnt_d  = cnt_q;
    if (en_i) begin
      cnt_d = wrap_o ? '0 : cnt_q + W'(1);
    end
    next_o   = cnt_d;
    active_o = cnt_d < ACT;
    sync_o   = (cnt_d >= S_LO) && (cnt_d < S_HI);
  end

  // Park on the last position so the first step hits 0.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= LAST;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with
// frame-start and line-prefetch strobes.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit H_POL    = 1'b0,
  parameter bit V_POL    = 1'b0,
  parameter int COL_W    = DEF_COL_W,
  parameter int ROW_W    = DEF_ROW_W,
  parameter int PREFETCH = DEF_PREFETCH
) (
  input  logic             clk,
  input  logic             rst,
  vga_timing_gen_if.master vga
);

  localparam int H_TOTAL =
    h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL =
    v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int HW = clog2(H_TOTAL + 1);
  localparam int VW = clog2(V_TOTAL + 1);
  localparam logic [HW-1:0] FETCH_AT =
    HW'(H_TOTAL - PREFETCH);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);

  if (COL_W < 1 || COL_W < clog2(H_ACTIVE))
  begin : g_col_chk
    $error("COL_W cannot hold H_ACTIVE-1");
  end
  if (ROW_W < 1 || ROW_W < clog2(V_ACTIVE))
  begin : g_row_chk
    $error("ROW_W cannot hold V_ACTIVE-1");
  end
  if (PREFETCH < 1 ||
      PREFETCH > H_FP + H_SYNC + H_BP)
  begin : g_pf_chk
    $error("PREFETCH outside horizontal blanking");
  end

  logic [HW-1:0] h_nx;
  logic [VW-1:0] v_nx, vline_nx;
  logic          h_wrap, v_wrap;
  logic          h_act, v_act;
  logic          h_sync, v_sync;

  vga_axis_counter #(
    .ACTIVE(H_ACTIVE), .FP(H_FP),
    .SYNC(H_SYNC), .BP(H_BP), .W(HW)
  ) u_h (
    .clk(clk), .rst(rst), .en_i(vga.pixEn),
    .wrap_o(h_wrap), .next_o(h_nx),
    .active_o(h_act), .sync_o(h_sync)
  );

  vga_axis_counter #(
    .ACTIVE(V_ACTIVE), .FP(V_FP),
    .SYNC(V_SYNC), .BP(V_BP), .W(VW)
  ) u_v (
    .clk(clk), .rst(rst), .en_i(h_wrap),
    .wrap_o(v_wrap), .next_o(v_nx),
    .active_o(v_act), .sync_o(v_sync)
  );

  logic             hs_q, hs_d;
  logic             vs_q, vs_d;
  logic             de_q, de_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic             fs_q, fs_d;
  logic             lf_q, lf_d;
  logic [ROW_W-1:0] fr_q, fr_d;

  // Decode outputs for the position reached this edge.
  always_comb begin
    vline_nx = (v_nx == V_LAST) ? '0 : v_nx + VW'(1);
    de_d  = h_act && v_act;
    hs_d  = h_sync ? H_POL : ~H_POL;
    vs_d  = v_sync ? V_POL : ~V_POL;
    col_d = de_d ? COL_W'(h_nx) : '0;
    row_d = de_d ? ROW_W'(v_nx) : '0;
    fs_d  = v_wrap;
    lf_d  = vga.pixEn && (h_nx == FETCH_AT) &&
            (vline_nx < V_ACT);
    fr_d  = lf_d ? ROW_W'(vline_nx) : fr_q;
  end

  // Output registers; reset wins over pixel enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      hs_q  <= ~H_POL;
      vs_q  <= ~V_POL;
      de_q  <= 1'b0;
      col_q <= '0;
      row_q <= '0;
      fs_q  <= 1'b0;
      lf_q  <= 1'b0;
      fr_q  <= '0;
    end else begin
      hs_q  <= hs_d;
      vs_q  <= vs_d;
      de_q  <= de_d;
      col_q <= col_d;
      row_q <= row_d;
      fs_q  <= fs_d;
      lf_q  <= lf_d;
      fr_q  <= fr_d;
    end
  end

  assign vga.hSync         = hs_q;
  assign vga.vSync         = vs_q;
  assign vga.displayActive = de_q;
  assign vga.column        = col_q;
  assign vga.row           = row_q;
  assign vga.frameStart    = fs_q;
  assign vga.lineFetch     = lf_q;
  assign vga.fetchRow      = fr_q;

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA raster timing generator, next generation of the fixed 640x480 controller in the display top level. It runs on the system clock gated by a pixel-clock enable (no divided clock domain), produces sync, active-video and pixel coordinates, and adds frame-start and line-prefetch strobes so a DDR line fetcher can fill a line buffer before each active line. It sits between the clock generator and the colour generator / DDR read path.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- H_POL, 0, hSync asserted level (0 = active-low)
- V_POL, 0, vSync asserted level (0 = active-low)
- COL_W, 10, column width; must hold H_ACTIVE-1
- ROW_W, 9, row/fetchRow width; must hold V_ACTIVE-1
- PREFETCH, 32, pixels before line end that lineFetch fires; 1 ≤ PREFETCH ≤ H_FP+H_SYNC+H_BP
- clk  in  1  system clock; one clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- pixEn  in  1  pixel advance enable; counters step only when high
- hSync  out  1  horizontal sync
- vSync  out  1  vertical sync
- displayActive  out  1  current pixel is visible
- column  out  COL_W  visible column; 0 during blanking
- row  out  ROW_W  visible row; 0 during blanking
- frameStart  out  1  one-clk pulse when raster enters pixel (0,0)
- lineFetch  out  1  one-clk pulse requesting the next active line
- fetchRow  out  ROW_W  row requested; valid while lineFetch high, held otherwise

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise. Defaults: 800 x 525.
- Internal hCount 0..H_TOTAL-1, vCount 0..V_TOTAL-1. Order per axis: active, front porch, sync, back porch.
- On clk with pixEn=1: hCount increments; at H_TOTAL-1 wraps to 0 and vCount increments; vCount wraps at V_TOTAL-1 to 0.
- Reset loads hCount=H_TOTAL-1, vCount=V_TOTAL-1, so the first pixEn lands on (0,0).
- displayActive = hCount<H_ACTIVE && vCount<V_ACTIVE.
- hSync = H_POL when H_ACTIVE+H_FP ≤ hCount < H_ACTIVE+H_FP+H_SYNC, else ~H_POL. vSync same on vCount with V_* (changes only at hCount wrap).
- column/row = hCount/vCount truncated when displayActive, else 0.
- frameStart: high for exactly one clk, the cycle after the pixEn edge that lands on (0,0).
- lineFetch: high for one clk after the pixEn edge that lands on hCount = H_TOTAL-PREFETCH, iff the next line (vCount+1, wrapped) is < V_ACTIVE. fetchRow = that next line; last blanking line requests row 0.
- pixEn=0: every output holds; strobes drop after their single cycle, never re-fire.

## Timing
- All outputs registered, mutually aligned; they reflect the counter position reached on the most recent pixEn edge.
- Reset values: hSync=~H_POL, vSync=~V_POL, displayActive=0, column=0, row=0, frameStart=0, lineFetch=0, fetchRow=0.
- rst mid-frame: next clk restores reset values; in-flight strobes cancelled; rst has priority over pixEn.
- pixEn held high permanently: one pixel per clk, frame period H_TOTAL*V_TOTAL clks.

## Structure
- Package vga_timing_pkg: default 640x480 timing constants, H_TOTAL/V_TOTAL functions, clog2 helper for width checks.
- One sub-module, vga_axis_counter: enable, wrap, active/sync window decode; instantiated twice (horizontal enabled by pixEn, vertical by horizontal wrap).
- Elaboration-time checks on COL_W/ROW_W and PREFETCH range.

## Test plan
- Reset, pixEn=1 constant, defaults -> first cycle displayActive=1, row=0, column=0, frameStart=1 for one clk; next frameStart exactly 420000 clks later.
- Defaults -> hSync low for hCount 656..751 (96 clks), vSync low for vCount 490..491 (1600 clks), displayActive low for column ≥640 and row ≥480.
- Defaults -> lineFetch at hCount 768 on each vCount 0..478 with fetchRow=vCount+1, at vCount 524 with fetchRow=0; none on vCount 479..523.
- pixEn toggled 1-of-3 -> identical output sequence stretched 3x; strobes still exactly one clk wide.
- Assert rst at (row 100, column 200) -> next clk all outputs at reset values; first pixEn after release gives (0,0) with frameStart.
- H_ACTIVE=4, H_FP=1, H_SYNC=1, H_BP=2, V_ACTIVE=2, V_FP=1, V_SYNC=1, V_BP=1, H_POL=1, PREFETCH=2 -> 40-clk frame, hSync high at hCount 5, lineFetch at hCount 6 of vCount 0 (fetchRow 1) and vCount 4 (fetchRow 0).
